// File: rtl/traffic_injector.sv
// Per-node single-flit traffic source for the mesh NoC: LFSR-driven Bernoulli launches,
// four destination patterns, and a Req/Gnt handshake into the router local port.
module traffic_injector #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DIM         = 4,
    parameter int unsigned PID_W       = 10,
    parameter int unsigned MID_W       = 6,
    parameter int unsigned MODULE_ID   = 0,
    parameter int unsigned MESH_X      = 5,
    parameter int unsigned MESH_Y      = 5,
    parameter int unsigned X_ID        = 0,
    parameter int unsigned Y_ID        = 0,
    parameter int unsigned HOT_X       = 0,
    parameter int unsigned HOT_Y       = 0,
    parameter int unsigned MAX_PACKETS = 1023,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Enable,
    input  logic [1:0]            Mode,
    input  logic [7:0]            RateThresh,
    input  logic                  DnStrFull,
    input  logic                  GntDnStr,
    output logic                  ReqDnStr,
    output logic [DATA_WIDTH-1:0] PacketOut,
    output logic [PID_W-1:0]      PacketCount,
    output logic [31:0]           CycleCounter,
    output logic [31:0]           StallCount,
    output logic                  Done
);

    typedef enum logic [1:0] {StIdle, StGen, StSendReq, StWaitGrant} stateE;

    localparam logic [7:0]       MeshX8 = 8'(MESH_X);
    localparam logic [7:0]       MeshY8 = 8'(MESH_Y);
    localparam logic [DIM-1:0]   SelfX  = DIM'(X_ID);
    localparam logic [DIM-1:0]   SelfY  = DIM'(Y_ID);
    localparam logic [DIM-1:0]   CompX  = DIM'(MESH_X - 1 - X_ID);
    localparam logic [DIM-1:0]   CompY  = DIM'(MESH_Y - 1 - Y_ID);
    localparam logic [DIM-1:0]   HotX   = DIM'(HOT_X);
    localparam logic [DIM-1:0]   HotY   = DIM'(HOT_Y);
    localparam logic [MID_W-1:0] ModId  = MID_W'(MODULE_ID);

    stateE                 stateQ, stateD;
    logic [15:0]           lfsrQ, lfsrD;
    logic [PID_W-1:0]      packetIdQ, packetIdD;
    logic [DIM-1:0]        xOffQ, xOffD, yOffQ, yOffD;
    logic                  reqQ, reqD;
    logic [DATA_WIDTH-1:0] packetOutQ, packetOutD;
    logic [PID_W-1:0]      packetCountQ, packetCountD;
    logic [31:0]           cycleCounterQ, cycleCounterD;
    logic [31:0]           stallCountQ, stallCountD;
    logic                  doneQ, doneD;

    logic [DIM-1:0]        dstX, dstY;
    logic signed [DIM:0]   diffX, diffY;
    logic [DIM-1:0]        xOffNew, yOffNew;
    logic                  isSelf;

    // Sign-magnitude offset: MSB set only for a strictly positive (East/North) hop count.
    function automatic logic [DIM-1:0] encodeOffset(logic signed [DIM:0] diff);
        logic [DIM:0] mag;
        mag = diff[DIM] ? 0 - diff : diff;
        return {diff > 0, (DIM-1)'(mag)};
    endfunction

    always_comb begin
        dstX = '0;
        dstY = '0;
        unique case (Mode)
            2'd0: begin
                dstX = DIM'(lfsrQ[15:8] % MeshX8);
                dstY = DIM'(lfsrQ[7:0] % MeshY8);
            end
            2'd1: begin
                dstX = SelfY;
                dstY = SelfX;
            end
            2'd2: begin
                dstX = CompX;
                dstY = CompY;
            end
            2'd3: begin
                dstX = HotX;
                dstY = HotY;
            end
            default: ;
        endcase
        diffX   = $signed({1'b0, dstX}) - $signed({1'b0, SelfX});
        diffY   = $signed({1'b0, dstY}) - $signed({1'b0, SelfY});
        xOffNew = encodeOffset(diffX);
        yOffNew = encodeOffset(diffY);
        isSelf  = (diffX == 0) && (diffY == 0);
    end

    always_comb begin
        stateD        = stateQ;
        lfsrD         = {1'b0, lfsrQ[15:1]} ^ (lfsrQ[0] ? 16'hB400 : 16'h0000);
        packetIdD     = packetIdQ;
        xOffD         = xOffQ;
        yOffD         = yOffQ;
        reqD          = reqQ;
        packetOutD    = packetOutQ;
        packetCountD  = packetCountQ;
        cycleCounterD = cycleCounterQ + 32'd1;
        stallCountD   = stallCountQ;
        doneD         = doneQ;
        unique case (stateQ)
            StIdle: begin
                if (Enable && !doneQ && (lfsrQ[7:0] < RateThresh)) begin
                    stateD = StGen;
                end
            end
            StGen: begin
                // A packet addressed to ourselves is dropped without consuming a PacketID.
                if (isSelf) begin
                    stateD = StIdle;
                end else begin
                    xOffD     = xOffNew;
                    yOffD     = yOffNew;
                    packetIdD = packetIdQ + 1'b1;
                    stateD    = StSendReq;
                end
            end
            StSendReq: begin
                if (!DnStrFull) begin
                    reqD       = 1'b1;
                    packetOutD = DATA_WIDTH'({xOffQ, yOffQ, {(2 * DIM){1'b0}}, packetIdQ, ModId});
                    stateD     = StWaitGrant;
                end else begin
                    stallCountD = stallCountQ + 32'd1;
                end
            end
            StWaitGrant: begin
                if (GntDnStr) begin
                    reqD         = 1'b0;
                    packetCountD = packetCountQ + 1'b1;
                    if (32'(packetCountQ) + 32'd1 == 32'(MAX_PACKETS)) begin
                        doneD = 1'b1;
                    end
                    stateD = StIdle;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ        <= StIdle;
            lfsrQ         <= LFSR_SEED;
            packetIdQ     <= '0;
            xOffQ         <= '0;
            yOffQ         <= '0;
            reqQ          <= 1'b0;
            packetOutQ    <= '0;
            packetCountQ  <= '0;
            cycleCounterQ <= '0;
            stallCountQ   <= '0;
            doneQ         <= 1'b0;
        end else begin
            stateQ        <= stateD;
            lfsrQ         <= lfsrD;
            packetIdQ     <= packetIdD;
            xOffQ         <= xOffD;
            yOffQ         <= yOffD;
            reqQ          <= reqD;
            packetOutQ    <= packetOutD;
            packetCountQ  <= packetCountD;
            cycleCounterQ <= cycleCounterD;
            stallCountQ   <= stallCountD;
            doneQ         <= doneD;
        end
    end

    assign ReqDnStr     = reqQ;
    assign PacketOut    = packetOutQ;
    assign PacketCount  = packetCountQ;
    assign CycleCounter = cycleCounterQ;
    assign StallCount   = stallCountQ;
    assign Done         = doneQ;

endmodule

// File: doc/traffic_injector.md
# traffic_injector

Parametrised per-node traffic source for the mesh NoC simulator. It generates single-flit packets using a synthesizable LFSR-based Bernoulli injection process and one of four destination patterns: uniform random, transpose, bit-complement or hotspot. Each packet is offered to the router local port through the ReqDnStr/GntDnStr/DnStrFull handshake. One instance sits on every router's local input; the traffic generator top sets mode and rate at run time.

## Interface
- DATA_WIDTH, 32: PacketOut width; must be ≥ 4*DIM+PID_W+MID_W.
- DIM, 4: coordinate field width (1 direction bit + DIM-1 hop bits).
- PID_W, 10: PacketID width.
- MID_W, 6: ModuleID width.
- MODULE_ID, 0: module ID placed in every packet.
- MESH_X, 5 / MESH_Y, 5: mesh size.
- X_ID, 0 / Y_ID, 0: this node's absolute coordinates.
- HOT_X, 0 / HOT_Y, 0: hotspot destination for mode 3.
- MAX_PACKETS, 1023: number of packets to inject before Done.
- LFSR_SEED, 16'hACE1: nonzero LFSR seed.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- Enable  in  1  allows new packet launches.
- Mode  in  2  0 uniform, 1 transpose, 2 bit-complement, 3 hotspot.
- RateThresh  in  8  launch probability per idle cycle = RateThresh/256.
- DnStrFull  in  1  local-port FIFO full.
- GntDnStr  in  1  grant from downstream router.
- ReqDnStr  out  1  request to downstream.
- PacketOut  out  DATA_WIDTH  packet word.
- PacketCount  out  PID_W  packets granted.
- CycleCounter  out  32  free-running timestamp.
- StallCount  out  32  cycles spent in SEND_REQ with DnStrFull=1.
- Done  out  1  sticky, MAX_PACKETS granted.

## Operation
- **Reset:** ReqDnStr=0, PacketOut=0, PacketCount=0, CycleCounter=0, StallCount=0, Done=0, PacketID=0, LFSR=LFSR_SEED, state IDLE.
- **LFSR:** 16-bit Galois, taps 16'hB400 (x^16+x^14+x^13+x^11+1). Advances every cycle out of reset.
- **IDLE:** if Enable & !Done & LFSR[7:0] < RateThresh, go to GEN; otherwise stay. RateThresh=0 never launches.
- **GEN:** compute the destination (dx,dy).
  - Mode 0: dx=LFSR[15:8]%MESH_X, dy=LFSR[7:0]%MESH_Y.
  - Mode 1: (Y_ID,X_ID).
  - Mode 2: (MESH_X-1-X_ID, MESH_Y-1-Y_ID).
  - Mode 3: (HOT_X,HOT_Y).
  - Offset fields are sign-magnitude: MSB=1 for East/North (dst>self), MSB=0 for West/South or zero; low DIM-1 bits = |dst-self|.
  - If dst==self, the packet is discarded: return to IDLE, PacketID unchanged.
  - Otherwise latch offsets, PacketID<=PacketID+1, go to SEND_REQ.
- **SEND_REQ:**
  - If !DnStrFull: ReqDnStr<=1, PacketOut<={zero pad, xDst, yDst, xSrc=0, ySrc=0, PacketID, MODULE_ID} (MSB→LSB), go to WAIT_GRANT.
  - Otherwise StallCount++ and stay.
- **WAIT_GRANT:** on GntDnStr=1: ReqDnStr<=0, PacketCount++, Done<=1 if PacketCount+1==MAX_PACKETS, go to IDLE. Otherwise hold.
- PacketOut holds its value until the next SEND_REQ launch.
- Enable deasserted mid-packet: the current packet completes; only launches from IDLE are gated.
- Mode/RateThresh changes take effect at the next IDLE/GEN evaluation.
- Reset asserted mid-handshake: ReqDnStr drops asynchronously and the in-flight packet is lost.
- GntDnStr outside WAIT_GRANT is ignored. DnStrFull is ignored in WAIT_GRANT.
- Arithmetic: counters wrap modulo 2^width. The offset subtraction is done at DIM+1 bits signed, then truncated to DIM-1 magnitude.

## Timing
- Decision to GEN: 1 cycle.
- GEN to SEND_REQ: 1 cycle.
- ReqDnStr rises 1 cycle after entering SEND_REQ with DnStrFull=0.
- Minimum packet period: 4 cycles (IDLE, GEN, SEND_REQ, WAIT_GRANT with grant in the first WAIT_GRANT cycle).
- ReqDnStr falls on the edge after GntDnStr is sampled high.
- PacketOut is valid on the same edge ReqDnStr rises.
- CycleCounter increments every cycle regardless of Enable/Done.

## Test plan
- Reset, RateThresh=255, Mode=1, X_ID=1, Y_ID=2, MODULE_ID=7, Gnt held 1 -> first PacketOut = {4'b1001,4'b0001,8'h00,10'd1,6'd7}; ReqDnStr high exactly 1 cycle; packets every 4 cycles.
- Mode=2 at (1,1) in 5x5 -> xDst=yDst=4'b1010. Mode=3 with HOT (0,0) -> xDst=yDst=4'b0001.
- Mode=1 at (2,2) -> no request ever; PacketID stays 0.
- DnStrFull=1 for 10 cycles during SEND_REQ -> ReqDnStr stays 0, StallCount=10; request asserts 1 cycle after Full drops.
- MAX_PACKETS=3, Gnt always 1 -> PacketCount=3, Done=1, no fourth request; reset clears Done.
- Reset pulse while ReqDnStr=1 and Gnt=0 -> ReqDnStr=0 immediately; PacketID restarts at 1 after release.
